// File: rtl/dct_row_butterfly_seq.sv
// Row-level first butterfly stage of an 8-point DCT: buffers one row of eight
// samples, then streams the four (x[i]+x[7-i], x[i]-x[7-i]) pairs downstream.
module dct_row_butterfly_seq #(
  parameter int WIDTH = 8
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic signed [WIDTH-2:0] Data_In,
  input  logic                    Valid_In,
  output logic                    Ready_In,
  output logic signed [WIDTH-1:0] Data_Add,
  output logic signed [WIDTH-1:0] Data_Sub,
  output logic [1:0]              Sele,
  output logic                    Valid_Out,
  input  logic                    Ready_Out,
  output logic [2:0]              Row_Cnt,
  output logic                    Row_Done,
  output logic                    Block_Done,
  output logic                    Dbg_State
);

  // Handshake: a beat moves on a rising edge only when valid and ready are both
  // high; while valid is high and ready is low the sender holds its data stable.

  typedef enum logic {LOAD = 1'b0, PROC = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic signed [WIDTH-2:0] buf_q [8];
  logic [2:0]              load_cnt;
  logic [1:0]              sele_q;
  logic [2:0]              row_cnt_q;
  logic signed [WIDTH-1:0] add_hold, sub_hold;
  logic signed [WIDTH-1:0] lo_ext, hi_ext, add_calc, sub_calc;
  logic [2:0]              lo_idx, hi_idx;
  logic                    accept, xfer, last_pair;
  logic                    row_done_q, block_done_q;

  always_comb begin
    accept    = (state == LOAD) && Valid_In;
    xfer      = (state == PROC) && Ready_Out;
    last_pair = xfer && (sele_q == 2'd3);
    state_nxt = state;
    case (state)
      LOAD:    if (accept && load_cnt == 3'd7) state_nxt = PROC;
      PROC:    if (last_pair)                  state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Both operands are sign-extended by one bit, so the sum/difference always fits.
  always_comb begin
    lo_idx   = {1'b0, sele_q};
    hi_idx   = 3'd7 - lo_idx;
    lo_ext   = {buf_q[lo_idx][WIDTH-2], buf_q[lo_idx]};
    hi_ext   = {buf_q[hi_idx][WIDTH-2], buf_q[hi_idx]};
    add_calc = lo_ext + hi_ext;
    sub_calc = lo_ext - hi_ext;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= LOAD;
      load_cnt     <= '0;
      sele_q       <= '0;
      row_cnt_q    <= '0;
      add_hold     <= '0;
      sub_hold     <= '0;
      row_done_q   <= 1'b0;
      block_done_q <= 1'b0;
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
    end else begin
      state        <= state_nxt;
      row_done_q   <= last_pair;
      block_done_q <= last_pair && (row_cnt_q == 3'd7);
      if (accept) begin
        buf_q[load_cnt] <= Data_In;
        load_cnt        <= load_cnt + 3'd1;
      end
      if (xfer) begin
        add_hold <= add_calc;
        sub_hold <= sub_calc;
        sele_q   <= sele_q + 2'd1;
      end
      if (last_pair) row_cnt_q <= row_cnt_q + 3'd1;
    end
  end

  // The buffer is refilled during LOAD, so the last pair is replayed from the hold registers.
  always_comb begin
    Ready_In   = (state == LOAD);
    Valid_Out  = (state == PROC);
    Data_Add   = (state == PROC) ? add_calc : add_hold;
    Data_Sub   = (state == PROC) ? sub_calc : sub_hold;
    Sele       = sele_q;
    Row_Cnt    = row_cnt_q;
    Row_Done   = row_done_q;
    Block_Done = block_done_q;
    Dbg_State  = state;
  end

endmodule

// File: doc/dct_row_butterfly_seq.md
DCT_ROW_BUTTERFLY_SEQ -- requirements
Module: dct_row_butterfly_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the output data width; input samples are WIDTH-1 bits signed.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port Data_In, input, WIDTH-1 signed, one pixel sample of the current row, x[0] first.
REQ-005 The block SHALL have port Valid_In, input, 1, meaning Data_In is valid this cycle.
REQ-006 The block SHALL have port Ready_In, output, 1, meaning the block accepts Data_In this cycle.
REQ-007 The block SHALL have port Data_Add, output, WIDTH signed, x[i]+x[7-i] for the current pair i.
REQ-008 The block SHALL have port Data_Sub, output, WIDTH signed, x[i]-x[7-i] for the current pair i.
REQ-009 The block SHALL have port Sele, output, 2, the pair index i (0..3) driving the downstream 1-to-4 selector.
REQ-010 The block SHALL have port Valid_Out, output, 1, meaning Data_Add, Data_Sub and Sele are valid.
REQ-011 The block SHALL have port Ready_Out, input, 1, meaning the downstream stage accepts the output this cycle.
REQ-012 The block SHALL have port Row_Cnt, output, 3, the index (0..7) of the row currently loaded or processed.
REQ-013 The block SHALL have port Row_Done, output, 1, a one-cycle pulse after the last pair of a row transfers.
REQ-014 The block SHALL have port Block_Done, output, 1, a one-cycle pulse coincident with Row_Done when Row_Cnt was 7.

Function
REQ-015 The block SHALL implement the FSM states LOAD and PROC only; reset enters LOAD.
REQ-016 In LOAD, Ready_In SHALL be 1, and each cycle with Valid_In=1 SHALL store Data_In into buffer slot Load_Cnt and increment Load_Cnt (3 bits).
REQ-017 Valid_In=0 in LOAD SHALL hold all state; gaps between samples are legal.
REQ-018 Acceptance of the sample with Load_Cnt=7 SHALL wrap Load_Cnt to 0 and move to PROC on the next edge, with Sele=0 and Valid_Out=1 in the first PROC cycle (latency: one cycle from the 8th accept to the first valid output).
REQ-019 In PROC, Ready_In SHALL be 0, and Valid_In SHALL be ignored.
REQ-020 In PROC, Data_Add and Data_Sub SHALL be computed from buffer slots Sele and 7-Sele, each sign-extended to WIDTH bits before add/subtract; no overflow or saturation is possible.
REQ-021 Outputs SHALL hold stable while Valid_Out=1 and Ready_Out=0.
REQ-022 A transfer (Valid_Out & Ready_Out) with Sele<3 SHALL increment Sele on the next edge.
REQ-023 A transfer with Sele=3 SHALL return to LOAD on the next edge with Valid_Out=0, Sele=0, Ready_In=1, Row_Done=1 for that one cycle, and Row_Cnt incremented mod 8.
REQ-024 Block_Done SHALL pulse with Row_Done only when the completed row had Row_Cnt=7, with Row_Cnt wrapping to 0.
REQ-025 Valid_Out SHALL be 0 in LOAD, and Data_Add, Data_Sub and Sele SHALL hold their last values there.
REQ-026 The buffer SHALL NOT be overwritten while in PROC.

Reset
REQ-027 When Rst=1 at a rising edge, the next state SHALL be: LOAD, Load_Cnt=0, Sele=0, Row_Cnt=0, Data_Add=0, Data_Sub=0, Valid_Out=0, Row_Done=0, Block_Done=0, Ready_In=1, buffer cleared to 0.
REQ-028 Rst SHALL take priority over every other event, including mid-load and mid-PROC with Ready_Out=0; a partially loaded or processed row SHALL be discarded.

Verification
REQ-029 Basic row: feed x=1,2,3,4,5,6,7,8 back-to-back with Ready_Out=1 -> 8th accept followed one cycle later by (Sele,Add,Sub)=(0,9,-7),(1,9,-5),(2,9,-3),(3,9,-1) on consecutive cycles, then Row_Done=1 and Ready_In=1.
REQ-030 Extremes (WIDTH=8): all x=-64 -> Add=-128, Sub=0; x[0..3]=63 and x[4..7]=-64 -> Add=-1, Sub=127 for every pair.
REQ-031 Backpressure: hold Ready_Out=0 for 3 cycles at Sele=1 -> outputs frozen at pair 1, and Sele advances only on the cycle after Ready_Out returns to 1.
REQ-032 Input gaps and PROC lockout: Valid_In toggled 1,0,1 during load -> only valid cycles counted; Valid_In=1 during PROC with Ready_In=0 -> buffer unchanged.
REQ-033 Eight rows -> Row_Cnt steps 0..7, Block_Done pulses once with the 8th Row_Done, then Row_Cnt=0.
REQ-034 Mid-row reset: Rst=1 after 5 samples, or at Sele=2 -> next cycle shows all REQ-027 reset values, and a fresh 8-sample row then yields correct results.
